load_align_unit: RTL and testbench
==================================

# load_align_unit

Parametrised, sequential load-data unit between the core's memory stage and the data-memory bus. Accepts one load request at a time, issues one or two aligned bus reads, then extracts, sign-/zero-extends and returns the result under a valid/ready handshake. Generalises the combinational load formatter to XLEN = 32 or 64 (adding LD and LWU), to split misaligned accesses, and to report faults.

## Interface
Parameters:
- XLEN, 32: data width; legal values 32 or 64.
- ADDR_W, 32: byte-address width.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRSTn  in  1  reset; asynchronous, active-low.
- iReqValid  in  1  load request present.
- oReqReady  out  1  unit can accept a request; high only in IDLE.
- iAddr  in  ADDR_W  byte address of the load.
- iFunct3  in  3  load type: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
- oMemRead  out  1  bus read strobe.
- oMemAddr  out  ADDR_W  bus address; always XLEN/8-aligned.
- iMemValid  in  1  bus data valid and read complete this cycle.
- iMemErr  in  1  bus error; sampled only with iMemValid.
- iMemData  in  XLEN  bus read data.
- oRespValid  out  1  result valid.
- iRespReady  in  1  consumer takes the result.
- oData  out  XLEN  extended load result; 0 whenever oErr ≠ 00.
- oErr  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 bus error.

## Operation
- States: IDLE, BEAT0, BEAT1, RESP. Reset state is IDLE.
- IDLE: oReqReady = 1. On iReqValid, latch iAddr and iFunct3.
  - Illegal funct3 goes to RESP with oErr 10. This covers 111 always, and 011 or 110 when XLEN = 32.
  - Misaligned request with the feature compiled out goes to RESP with oErr 01.
  - Otherwise go to BEAT0.
- Offset and size: off = addr[log2(XLEN/8)-1:0]; n = 1, 2, 4 or 8 bytes. The access is split when off + n > XLEN/8.
- BEAT0: oMemRead = 1, oMemAddr = addr with the low offset bits cleared. Strobe and address are held until iMemValid.
  - On iMemValid with iMemErr: go to RESP with oErr 11.
  - On iMemValid without iMemErr: capture the data into lo, then go to BEAT1 if split, else RESP.
- BEAT1: same as BEAT0 at address + XLEN/8; the sum wraps modulo 2^ADDR_W. Capture the data into hi, then go to RESP, or go to RESP with oErr 11 on iMemErr.
- Result formation: take the {hi, lo} 2·XLEN vector and shift it right by off·8. Keep the low n bytes. Sign-extend for LB/LH/LW/LD; zero-extend for LBU/LHU/LWU.
- RESP: oRespValid = 1. oData and oErr are registered and stable until the handshake. On iRespReady go to IDLE. A new request is not accepted in the same cycle.
- Reset asserted mid-operation: return to IDLE immediately and drop any outstanding bus read. The bus must tolerate an abandoned strobe.

## Timing
- Reset values: oReqReady 1 (IDLE), oMemRead 0, oMemAddr 0, oRespValid 0, oData 0, oErr 00.
- oReqReady, oMemRead and oRespValid are decoded from registered state only, with no combinational input-to-output paths.
- Minimum latency from request accept (cycle 0), assuming zero-wait memory and iRespReady held high:
  - aligned: oMemRead in cycle 1, oRespValid in cycle 2;
  - split: oMemRead in cycles 1–2, oRespValid in cycle 3;
  - fault detected in IDLE: oRespValid in cycle 1.
- Each bus wait cycle adds one cycle of latency. Throughput is one request per (latency + 1) cycles.
- iMemValid outside BEAT0/BEAT1 is ignored.

## Configuration
- MISALIGNED_LOAD_EN defined: misaligned loads are split across two beats as described; oErr 01 is never produced.
- MISALIGNED_LOAD_EN undefined:
  - any load with off not a multiple of n returns oErr 01 with no bus access;
  - BEAT1 logic and the hi register are removed.

## Test plan
- Aligned LW at 0x1000, XLEN = 32, iMemData 0x8765_4321 → oMemAddr 0x1000, oData 0x8765_4321, oErr 00, oRespValid in cycle 2.
- LB at 0x1003 with data 0x80xx_xxxx → 0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- Split LW at 0x1002, memory returns 0xBBBB_AAAA then 0xDDDD_CCCC:
  - with MISALIGNED_LOAD_EN: reads at 0x1000 then 0x1004, result 0xCCCC_BBBB;
  - without the macro: oErr 01, oData 0, oMemRead never asserted.
- XLEN = 64: LWU at 0x8 with data 0x0000_0000_F000_0001 → 0x0000_0000_F000_0001. LD at 0x8 with XLEN = 32 → oErr 10.
- Bus wait and error handling:
  - 3 wait cycles on BEAT0 → oMemAddr held stable, response in cycle 5;
  - iMemErr on BEAT1 of a split load → oErr 11, oData 0.
- Backpressure and reset:
  - iRespReady low for 4 cycles → oData/oErr held, oReqReady low throughout;
  - iRSTn pulsed low during BEAT0 → IDLE, all outputs at reset values.

Source files
------------

// File: rtl/load_align_unit_if.sv
// Request, data-bus and response signals of load_align_unit, bundled with
// a slave view for the unit and a master view for the core/bus side.
interface load_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              iReqValid;
    logic              oReqReady;
    logic [ADDR_W-1:0] iAddr;
    logic [2:0]        iFunct3;
    logic              oMemRead;
    logic [ADDR_W-1:0] oMemAddr;
    logic              iMemValid;
    logic              iMemErr;
    logic [XLEN-1:0]   iMemData;
    logic              oRespValid;
    logic              iRespReady;
    logic [XLEN-1:0]   oData;
    logic [1:0]        oErr;

    modport slave (
        input  iReqValid, iAddr, iFunct3, iMemValid, iMemErr, iMemData, iRespReady,
        output oReqReady, oMemRead, oMemAddr, oRespValid, oData, oErr
    );

    modport master (
        output iReqValid, iAddr, iFunct3, iMemValid, iMemErr, iMemData, iRespReady,
        input  oReqReady, oMemRead, oMemAddr, oRespValid, oData, oErr
    );
endinterface

// File: rtl/load_align_unit.sv
// Sequential load unit: aligned bus reads, byte extraction and sign/zero extension.
// Define MISALIGNED_LOAD_EN to split misaligned loads over two beats; otherwise they fault.
module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    load_align_unit_if.slave  bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t            state, state_nxt;
    logic [OFF_W-1:0]  off_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [XLEN-1:0]   data_q;
    logic [1:0]        err_q;
    logic [OFF_W-1:0]  req_off;
    logic [1:0]        req_err;
    logic              split;

    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b111) || ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)));
    endfunction

    // Shift the beat pair down to the addressed byte, then extend by load type.
    function automatic logic [XLEN-1:0] extend_load(input logic [2*XLEN-1:0] pair,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [2:0]        f3);
        logic [2*XLEN-1:0] sh;
        sh = pair >> {off, 3'b000};
        case (f3)
            3'b000:  return XLEN'($signed(sh[7:0]));
            3'b001:  return XLEN'($signed(sh[15:0]));
            3'b010:  return XLEN'($signed(sh[31:0]));
            3'b100:  return XLEN'(sh[7:0]);
            3'b101:  return XLEN'(sh[15:0]);
            3'b110:  return XLEN'(sh[31:0]);
            default: return sh[XLEN-1:0];
        endcase
    endfunction

    assign req_off = bus.iAddr[OFF_W-1:0];

    always_comb begin
        req_err = 2'b00;
        if (illegal_f3(bus.iFunct3)) begin
            req_err = 2'b10;
        end
`ifndef MISALIGNED_LOAD_EN
        else if ((req_off & OFF_W'(size_bytes(bus.iFunct3) - 4'd1)) != '0) begin
            req_err = 2'b01;
        end
`endif
    end

`ifdef MISALIGNED_LOAD_EN
    logic [XLEN-1:0] lo_q;

    assign split = (5'(off_q) + 5'(size_bytes(f3_q))) > 5'(NB);

    always_ff @(posedge iCLK) begin
        if (state == BEAT0 && bus.iMemValid) begin
            lo_q <= bus.iMemData;
        end
    end
`else
    assign split = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.iReqValid) state_nxt = (req_err != 2'b00) ? RESP : BEAT0;
            BEAT0:   if (bus.iMemValid) state_nxt = (!bus.iMemErr && split) ? BEAT1 : RESP;
`ifdef MISALIGNED_LOAD_EN
            BEAT1:   if (bus.iMemValid) state_nxt = RESP;
`endif
            RESP:    if (bus.iRespReady) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, bus address stepping and result registers.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            off_q   <= '0;
            f3_q    <= '0;
            maddr_q <= '0;
            data_q  <= '0;
            err_q   <= 2'b00;
        end else begin
            case (state)
                IDLE: if (bus.iReqValid) begin
                    off_q   <= req_off;
                    f3_q    <= bus.iFunct3;
                    maddr_q <= {bus.iAddr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    data_q  <= '0;
                    err_q   <= req_err;
                end
                BEAT0: if (bus.iMemValid) begin
                    if (bus.iMemErr) begin
                        err_q <= 2'b11;
                    end else if (split) begin
                        maddr_q <= maddr_q + ADDR_W'(NB);
                    end else begin
                        data_q <= extend_load({{XLEN{1'b0}}, bus.iMemData}, off_q, f3_q);
                    end
                end
`ifdef MISALIGNED_LOAD_EN
                BEAT1: if (bus.iMemValid) begin
                    if (bus.iMemErr) begin
                        err_q <= 2'b11;
                    end else begin
                        data_q <= extend_load({bus.iMemData, lo_q}, off_q, f3_q);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.oReqReady  = (state == IDLE);
    assign bus.oMemRead   = (state == BEAT0) || (state == BEAT1);
    assign bus.oRespValid = (state == RESP);
    assign bus.oMemAddr   = maddr_q;
    assign bus.oData      = data_q;
    assign bus.oErr       = err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: XLEN=32 and XLEN=64 instances sharing clock and reset.
module tb_load_align_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    load_align_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    load_align_unit #(.XLEN(32), .ADDR_W(32)) u32 (.iCLK(clk), .iRSTn(rst_n), .bus(b32.slave));
    load_align_unit #(.XLEN(64), .ADDR_W(32)) u64 (.iCLK(clk), .iRSTn(rst_n), .bus(b64.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"},  64'(b32.oReqReady), 64'd1);
        chk({tag, "_rd"},   64'(b32.oMemRead), 64'd0);
        chk({tag, "_addr"}, 64'(b32.oMemAddr), 64'd0);
        chk({tag, "_vld"},  64'(b32.oRespValid), 64'd0);
        chk({tag, "_data"}, 64'(b32.oData), 64'd0);
        chk({tag, "_err"},  64'(b32.oErr), 64'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [2:0] f);
        b32.iReqValid = 1'b1;
        b32.iAddr     = a;
        b32.iFunct3   = f;
        step();
        b32.iReqValid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] d, input logic e);
        chk({tag, "_rd"},   64'(b32.oMemRead), 64'd1);
        chk({tag, "_addr"}, 64'(b32.oMemAddr), 64'(a));
        b32.iMemValid = 1'b1;
        b32.iMemData  = d;
        b32.iMemErr   = e;
        step();
        b32.iMemValid = 1'b0;
        b32.iMemErr   = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [31:0] d, input logic [1:0] e);
        chk({tag, "_vld"},  64'(b32.oRespValid), 64'd1);
        chk({tag, "_data"}, 64'(b32.oData), 64'(d));
        chk({tag, "_err"},  64'(b32.oErr), 64'(e));
        chk({tag, "_nord"}, 64'(b32.oMemRead), 64'd0);
        step();
        chk({tag, "_idle"}, 64'(b32.oReqReady), 64'd1);
    endtask

    task automatic load64(input string tag, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] bus_addr, input logic [63:0] d, input logic [63:0] exp);
        b64.iReqValid = 1'b1;
        b64.iAddr     = a;
        b64.iFunct3   = f;
        step();
        b64.iReqValid = 1'b0;
        chk({tag, "_rd"},   64'(b64.oMemRead), 64'd1);
        chk({tag, "_addr"}, 64'(b64.oMemAddr), 64'(bus_addr));
        b64.iMemValid = 1'b1;
        b64.iMemData  = d;
        step();
        b64.iMemValid = 1'b0;
        chk({tag, "_vld"},  64'(b64.oRespValid), 64'd1);
        chk({tag, "_data"}, b64.oData, exp);
        chk({tag, "_err"},  64'(b64.oErr), 64'd0);
        step();
    endtask

    initial begin
        b32.iReqValid = 1'b0; b32.iAddr = '0; b32.iFunct3 = '0;
        b32.iMemValid = 1'b0; b32.iMemErr = 1'b0; b32.iMemData = '0; b32.iRespReady = 1'b1;
        b64.iReqValid = 1'b0; b64.iAddr = '0; b64.iFunct3 = '0;
        b64.iMemValid = 1'b0; b64.iMemErr = 1'b0; b64.iMemData = '0; b64.iRespReady = 1'b1;

        step();
        step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // Aligned LW: read in cycle 1, response in cycle 2.
        chk("lw_rdy0", 64'(b32.oReqReady), 64'd1);
        issue(32'h1000, 3'b010);
        beat("lw", 32'h1000, 32'h8765_4321, 1'b0);
        resp("lw", 32'h8765_4321, 2'b00);

        issue(32'h1003, 3'b000);
        beat("lb", 32'h1000, 32'h8012_3456, 1'b0);
        resp("lb", 32'hFFFF_FF80, 2'b00);

        issue(32'h1003, 3'b100);
        beat("lbu", 32'h1000, 32'h8012_3456, 1'b0);
        resp("lbu", 32'h0000_0080, 2'b00);

        issue(32'h1002, 3'b101);
        beat("lhu", 32'h1000, 32'h7FFE_0000, 1'b0);
        resp("lhu", 32'h0000_7FFE, 2'b00);

        // Word load at offset 2.
        issue(32'h1002, 3'b010);
`ifdef MISALIGNED_LOAD_EN
        beat("lws0", 32'h1000, 32'hBBBB_AAAA, 1'b0);
        beat("lws1", 32'h1004, 32'hDDDD_CCCC, 1'b0);
        resp("lws", 32'hCCCC_BBBB, 2'b00);
`else
        resp("lwmis", 32'h0, 2'b01);
`endif

        issue(32'h0000_0008, 3'b011);
        resp("ld32", 32'h0, 2'b10);
        issue(32'h0000_0000, 3'b111);
        resp("f3_111", 32'h0, 2'b10);

        // Three wait cycles on BEAT0: address held, response in cycle 5.
        issue(32'h1006, 3'b001);
        for (int i = 0; i < 3; i++) begin
            chk("wait_rd", 64'(b32.oMemRead), 64'd1);
            chk("wait_addr", 64'(b32.oMemAddr), 64'h1004);
            chk("wait_vld", 64'(b32.oRespValid), 64'd0);
            step();
        end
        beat("lhw", 32'h1004, 32'hF00D_5678, 1'b0);
        resp("lhw", 32'hFFFF_F00D, 2'b00);

        issue(32'h1010, 3'b010);
        beat("be0", 32'h1010, 32'h1234_5678, 1'b1);
        resp("be0", 32'h0, 2'b11);

`ifdef MISALIGNED_LOAD_EN
        issue(32'h1012, 3'b010);
        beat("be1a", 32'h1010, 32'h1111_2222, 1'b0);
        beat("be1b", 32'h1014, 32'h3333_4444, 1'b1);
        resp("be1", 32'h0, 2'b11);
`endif

        // Backpressure with a competing request held high.
        b32.iRespReady = 1'b0;
        issue(32'h1002, 3'b101);
        beat("bp", 32'h1000, 32'h8001_7777, 1'b0);
        b32.iReqValid = 1'b1;
        b32.iAddr     = 32'h2000;
        b32.iFunct3   = 3'b010;
        for (int i = 0; i < 4; i++) begin
            chk("bp_vld", 64'(b32.oRespValid), 64'd1);
            chk("bp_data", 64'(b32.oData), 64'h0000_8001);
            chk("bp_err", 64'(b32.oErr), 64'd0);
            chk("bp_rdy", 64'(b32.oReqReady), 64'd0);
            step();
        end
        b32.iRespReady = 1'b1;
        step();
        chk("bp_idle_rdy", 64'(b32.oReqReady), 64'd1);
        chk("bp_idle_rd", 64'(b32.oMemRead), 64'd0);
        chk("bp_idle_vld", 64'(b32.oRespValid), 64'd0);
        b32.iReqValid = 1'b0;
        step();

        // Stray bus completion in IDLE is ignored.
        b32.iMemValid = 1'b1;
        b32.iMemErr   = 1'b1;
        step();
        b32.iMemValid = 1'b0;
        b32.iMemErr   = 1'b0;
        chk("stray_rdy", 64'(b32.oReqReady), 64'd1);
        chk("stray_vld", 64'(b32.oRespValid), 64'd0);

        load64("lwu64", 32'h8, 3'b110, 32'h8, 64'h0000_0000_F000_0001, 64'h0000_0000_F000_0001);
        load64("lw64",  32'h8, 3'b010, 32'h8, 64'h0000_0000_F000_0001, 64'hFFFF_FFFF_F000_0001);
        load64("lwu64h", 32'hC, 3'b110, 32'h8, 64'hCAFE_BABE_0000_0000, 64'h0000_0000_CAFE_BABE);
        load64("ld64",  32'h10, 3'b011, 32'h10, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);

        // Reset pulsed during BEAT0.
        issue(32'h2000, 3'b010);
        chk("mid_rd", 64'(b32.oMemRead), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_rdy", 64'(b32.oReqReady), 64'd1);
        chk("post_rst_rd", 64'(b32.oMemRead), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
